// File: rtl/sm_channel_llr_loader.sv
// Channel LLR loader: converts two's-complement LLRs to sign-magnitude and
// buffers one frame for address-based reads by the SC decoder.
module sm_channel_llr_loader #(
    parameter int Q     = 8,
    parameter int N     = 16,
    parameter int LOG2N = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [Q-1:0]     IN_LLR,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic             FRAME_READY,
    input  logic [LOG2N-1:0] RD_ADDR,
    input  logic             RD_EN,
    output logic [Q-2:0]     RD_VAL,
    output logic             RD_SIGN,
    output logic             RD_VALID,
    input  logic             FRAME_DONE,
    output logic [7:0]       OVF_CNT
);

    typedef enum logic {
        LOAD = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic signed [Q-1:0] LLR_MIN  = {1'b1, {(Q-1){1'b0}}};
    localparam logic [LOG2N-1:0]    PTR_LAST = LOG2N'(N - 1);

    // Returns {saturated, sign, magnitude}; zero is always stored as +0.
    function automatic logic [Q:0] to_sign_mag(input logic signed [Q-1:0] x);
        logic signed [Q-1:0] neg;
        logic [Q-2:0]        mag;
        logic                sat;
        neg = -x;
        sat = (x == LLR_MIN);
        if (!x[Q-1])
            mag = x[Q-2:0];
        else if (sat)
            mag = '1;
        else
            mag = neg[Q-2:0];
        return {sat, x[Q-1], mag};
    endfunction

    state_t           state;
    logic [LOG2N-1:0] wr_ptr;
    logic [Q-1:0]     mem [N];
    logic [Q:0]       conv_p0;
    logic             wr_en_p0;
    logic             rd_en_p0;

    assign conv_p0  = to_sign_mag(IN_LLR);
    assign wr_en_p0 = (state == LOAD) && IN_VALID && IN_READY;
    assign rd_en_p0 = (state == HOLD) && RD_EN;

    // Control FSM: write pointer, handshake flags and overflow count.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= LOAD;
            wr_ptr      <= '0;
            IN_READY    <= 1'b0;
            FRAME_READY <= 1'b0;
            OVF_CNT     <= '0;
        end else begin
            case (state)
                LOAD: begin
                    IN_READY    <= 1'b1;
                    FRAME_READY <= 1'b0;
                    if (wr_en_p0) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (wr_ptr == '0)
                            OVF_CNT <= conv_p0[Q] ? 8'd1 : 8'd0;
                        else if (conv_p0[Q] && (OVF_CNT != 8'hFF))
                            OVF_CNT <= OVF_CNT + 8'd1;
                        if (wr_ptr == PTR_LAST) begin
                            state       <= HOLD;
                            IN_READY    <= 1'b0;
                            FRAME_READY <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    IN_READY    <= 1'b0;
                    FRAME_READY <= 1'b1;
                    if (FRAME_DONE) begin
                        state       <= LOAD;
                        IN_READY    <= 1'b1;
                        FRAME_READY <= 1'b0;
                    end
                end
                default: begin
                    state    <= LOAD;
                    IN_READY <= 1'b0;
                end
            endcase
        end
    end

    // Frame buffer: written only in LOAD, so it never collides with a read.
    always_ff @(posedge CLK) begin
        if (wr_en_p0)
            mem[wr_ptr] <= conv_p0[Q-1:0];
    end

    // Read stage: one cycle from RD_EN to RD_VALID.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            RD_VAL   <= '0;
            RD_SIGN  <= 1'b0;
            RD_VALID <= 1'b0;
        end else begin
            RD_VALID <= rd_en_p0;
            if (rd_en_p0) begin
                RD_SIGN <= mem[RD_ADDR][Q-2+1];
                RD_VAL  <= mem[RD_ADDR][Q-2:0];
            end
        end
    end

endmodule

// File: tb/tb_sm_channel_llr_loader.sv
// Directed bench for sm_channel_llr_loader: conversion, saturation, handshake,
// gapped input, read path and asynchronous reset.
module tb_sm_channel_llr_loader;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [7:0] IN_LLR;
    logic       IN_VALID;
    logic       IN_READY;
    logic       FRAME_READY;
    logic [3:0] RD_ADDR;
    logic       RD_EN;
    logic [6:0] RD_VAL;
    logic       RD_SIGN;
    logic       RD_VALID;
    logic       FRAME_DONE;
    logic [7:0] OVF_CNT;

    int total = 0;
    int bad   = 0;
    logic signed [7:0] frame [16];

    sm_channel_llr_loader #(.Q(8), .N(16), .LOG2N(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .IN_LLR(IN_LLR), .IN_VALID(IN_VALID),
        .IN_READY(IN_READY), .FRAME_READY(FRAME_READY), .RD_ADDR(RD_ADDR),
        .RD_EN(RD_EN), .RD_VAL(RD_VAL), .RD_SIGN(RD_SIGN), .RD_VALID(RD_VALID),
        .FRAME_DONE(FRAME_DONE), .OVF_CNT(OVF_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input int first, input int last, input bit gapped);
        for (int i = first; i <= last; i++) begin
            IN_LLR   = frame[i];
            IN_VALID = 1'b1;
            chk("in_ready_load", {31'd0, IN_READY}, 32'd1);
            tick();
            if (gapped && i != last) begin
                IN_VALID = 1'b0;
                IN_LLR   = 8'h5a;
                tick();
            end
        end
        IN_VALID = 1'b0;
    endtask

    task automatic rd(input string tag, input int addr, input int val, input int sgn);
        RD_ADDR = addr[3:0];
        RD_EN   = 1'b1;
        tick();
        RD_EN   = 1'b0;
        chk({tag, "_valid"}, {31'd0, RD_VALID}, 32'd1);
        chk({tag, "_val"},   {25'd0, RD_VAL},   val);
        chk({tag, "_sign"},  {31'd0, RD_SIGN},  sgn);
    endtask

    task automatic release_frame();
        FRAME_DONE = 1'b1;
        tick();
        FRAME_DONE = 1'b0;
        chk("in_ready_after_done", {31'd0, IN_READY}, 32'd1);
        chk("frame_ready_after_done", {31'd0, FRAME_READY}, 32'd0);
    endtask

    initial begin
        RST_N = 1'b0; IN_LLR = '0; IN_VALID = 1'b0; RD_ADDR = '0;
        RD_EN = 1'b0; FRAME_DONE = 1'b0;
        repeat (3) tick();
        chk("rst_in_ready", {31'd0, IN_READY}, 0);
        chk("rst_frame_ready", {31'd0, FRAME_READY}, 0);
        chk("rst_rd_valid", {31'd0, RD_VALID}, 0);
        chk("rst_rd_val", {25'd0, RD_VAL}, 0);
        chk("rst_rd_sign", {31'd0, RD_SIGN}, 0);
        chk("rst_ovf", {24'd0, OVF_CNT}, 0);
        RST_N = 1'b1;
        chk("in_ready_before_first_clk", {31'd0, IN_READY}, 0);
        tick();
        chk("in_ready_first_clk", {31'd0, IN_READY}, 1);

        // Frame 1: 0,1,-1,2,-2,...,7,-7,127
        frame[0] = 8'sd0;
        for (int k = 1; k <= 7; k++) begin
            frame[2*k-1] = 8'(k);
            frame[2*k]   = 8'(-k);
        end
        frame[15] = 8'sd127;
        send(0, 14, 1'b0);
        chk("f1_frame_ready_at_15", {31'd0, FRAME_READY}, 0);
        send(15, 15, 1'b0);
        chk("f1_frame_ready", {31'd0, FRAME_READY}, 1);
        chk("f1_in_ready", {31'd0, IN_READY}, 0);
        chk("f1_ovf", {24'd0, OVF_CNT}, 0);
        rd("f1_a2", 2, 1, 1);
        rd("f1_a15", 15, 127, 0);
        rd("f1_a0", 0, 0, 0);
        rd("f1_a14", 14, 7, 1);
        tick();
        chk("f1_rd_valid_drop", {31'd0, RD_VALID}, 0);
        chk("f1_rd_val_hold", {25'd0, RD_VAL}, 7);

        // Backpressure in HOLD
        IN_VALID = 1'b1;
        for (int k = 0; k < 10; k++) begin
            IN_LLR = 8'(55 + k);
            tick();
        end
        chk("bp_in_ready", {31'd0, IN_READY}, 0);
        chk("bp_frame_ready", {31'd0, FRAME_READY}, 1);
        IN_VALID = 1'b0;
        rd("bp_a2", 2, 1, 1);
        rd("bp_a0", 0, 0, 0);
        release_frame();

        // Frame 2: saturation at addr 3, -127 at addr 4
        for (int k = 0; k < 16; k++) frame[k] = 8'(10 + k);
        frame[0] = -8'sd5;
        frame[3] = -8'sd128;
        frame[4] = -8'sd127;
        send(0, 15, 1'b0);
        chk("f2_frame_ready", {31'd0, FRAME_READY}, 1);
        chk("f2_ovf", {24'd0, OVF_CNT}, 1);
        rd("f2_a3", 3, 127, 1);
        rd("f2_a4", 4, 127, 1);
        rd("f2_a0", 0, 5, 1);
        rd("f2_a1", 1, 11, 0);

        // FRAME_DONE together with RD_EN
        RD_ADDR = 4'd5; RD_EN = 1'b1; FRAME_DONE = 1'b1;
        tick();
        RD_EN = 1'b0; FRAME_DONE = 1'b0;
        chk("done_rd_valid", {31'd0, RD_VALID}, 1);
        chk("done_rd_val", {25'd0, RD_VAL}, 15);
        chk("done_rd_sign", {31'd0, RD_SIGN}, 0);
        chk("done_in_ready", {31'd0, IN_READY}, 1);
        chk("done_frame_ready", {31'd0, FRAME_READY}, 0);
        RD_ADDR = 4'd3; RD_EN = 1'b1;
        tick();
        RD_EN = 1'b0;
        chk("load_rd_valid", {31'd0, RD_VALID}, 0);
        chk("load_rd_val_hold", {25'd0, RD_VAL}, 15);
        chk("load_ovf_hold", {24'd0, OVF_CNT}, 1);

        // Frame 3: gapped input
        for (int k = 0; k < 16; k++)
            frame[k] = (k % 2 == 1) ? 8'(-(k + 20)) : 8'(k + 40);
        send(0, 0, 1'b0);
        chk("f3_ovf_clear", {24'd0, OVF_CNT}, 0);
        IN_VALID = 1'b0;
        tick();
        send(1, 14, 1'b1);
        chk("f3_gap_frame_ready_at_15", {31'd0, FRAME_READY}, 0);
        tick();
        chk("f3_gap_frame_ready_idle", {31'd0, FRAME_READY}, 0);
        send(15, 15, 1'b0);
        chk("f3_frame_ready", {31'd0, FRAME_READY}, 1);
        rd("f3_a7", 7, 27, 1);
        rd("f3_a8", 8, 48, 0);
        rd("f3_a1", 1, 21, 1);

        // Async reset mid-HOLD with RD_VALID high
        RD_ADDR = 4'd8; RD_EN = 1'b1;
        tick();
        RD_EN = 1'b0;
        chk("pre_rst_rd_valid", {31'd0, RD_VALID}, 1);
        #2 RST_N = 1'b0;
        #1;
        chk("hold_rst_rd_valid", {31'd0, RD_VALID}, 0);
        chk("hold_rst_frame_ready", {31'd0, FRAME_READY}, 0);
        chk("hold_rst_rd_val", {25'd0, RD_VAL}, 0);
        #1 RST_N = 1'b1;
        tick();

        // Async reset mid-LOAD after 9 transfers
        for (int k = 0; k < 16; k++) frame[k] = 8'(-(k + 1));
        frame[2] = -8'sd128;
        send(0, 8, 1'b0);
        chk("mid_ovf", {24'd0, OVF_CNT}, 1);
        #2 RST_N = 1'b0;
        #1;
        chk("load_rst_in_ready", {31'd0, IN_READY}, 0);
        chk("load_rst_frame_ready", {31'd0, FRAME_READY}, 0);
        chk("load_rst_ovf", {24'd0, OVF_CNT}, 0);
        #1 RST_N = 1'b1;
        tick();
        for (int k = 0; k < 16; k++) frame[k] = 8'(3 * k);
        send(0, 14, 1'b0);
        chk("rst_fresh_frame_ready_at_15", {31'd0, FRAME_READY}, 0);
        send(15, 15, 1'b0);
        chk("rst_fresh_frame_ready", {31'd0, FRAME_READY}, 1);
        rd("rst_a0", 0, 0, 0);
        rd("rst_a9", 9, 27, 0);
        rd("rst_a15", 15, 45, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
